sync_clk_tracker: RTL
=====================

# sync_clk_tracker

- Parametrised, multi-channel successor to the single-channel sync-clock counter of the Sigma Delta DAQ.
- A shared cyclic counter runs with a programmable period. Each channel checks that its external sync strobe lands inside a tolerance window around counter wrap.
- Lock, sticky error and (optionally) captured phase are reported per channel. `errorFlag` is exported to the register bank.

## Interface
Parameters:
- `COUNTER_SIZE`, 19, width of counter and period.
- `NUM_CHANNELS`, 4, number of monitored sync inputs.
- `TOLERANCE`, 2, half-width of the acceptance window, in clocks.

Ports:
- `clk` input 1: sole clock.
- `reset_n` input 1: reset, asynchronous, active-low.
- `resetCyclic` input 1: restart counter, latch `periodIn`.
- `clearError` input 1: clear all channel errors.
- `periodIn` input COUNTER_SIZE: cycle length P; sampled only on reset release and `resetCyclic`.
- `syncPulse` input NUM_CHANNELS: one-clock strobes, already synchronous to `clk`.
- `syncCounter` output COUNTER_SIZE: current count, 0..P-1.
- `cycleTick` output 1: one-clock pulse on each wrap to 0.
- `channelLocked` output NUM_CHANNELS: channel in LOCKED.
- `channelError` output NUM_CHANNELS: channel in ERROR.
- `errorFlag` output 1: OR of `channelError`, combinational from registers.
- `phaseCapture` output NUM_CHANNELS*COUNTER_SIZE: counter value at last accepted pulse, channel 0 in LSBs.

## Operation
- Effective period `Peff = max(periodIn, 2*TOLERANCE+2)`. Invalid small periods are clamped, not flagged.
- Counter:
  - `resetCyclic` forces 0 next edge.
  - Otherwise at `Peff-1` it wraps to 0, else it increments.
- Window is open when `syncCounter >= Peff-TOLERANCE` or `syncCounter <= TOLERANCE`.
- Window close occurs at `syncCounter == TOLERANCE+1`.
- Per-channel FSM, with states UNLOCKED, LOCKED, ERROR:
  - UNLOCKED → LOCKED on any pulse inside the window.
  - UNLOCKED ignores pulses outside the window.
  - LOCKED → ERROR on a pulse outside the window.
  - LOCKED → ERROR on a second pulse in the same window.
  - LOCKED → ERROR at window close with no pulse seen (missing pulse).
  - ERROR holds until `clearError`, then → UNLOCKED.
- The per-channel `seen` bit is set on an accepted pulse and cleared at window close.
- Priority, highest first: `clearError`, then `resetCyclic`, then pulse/timeout evaluation.
  - `clearError`: all channels → UNLOCKED, `seen` cleared, any pulse in that cycle ignored.
  - `resetCyclic`: LOCKED channels → UNLOCKED, ERROR retained, pulses that cycle ignored.
- Evaluation uses the pre-edge `syncCounter` value.

## Timing
- Reset values: `syncCounter`=0, `cycleTick`=0, `channelLocked`=0, `channelError`=0, `errorFlag`=0, `phaseCapture`=0, all channels UNLOCKED, P = `periodIn` at reset release.
- Pulse at edge n: state, `channelLocked`/`channelError` and `phaseCapture` update at edge n+1 (1-clock latency).
- `errorFlag` follows `channelError` in the same cycle.
- `cycleTick` is high exactly during the cycle where `syncCounter`==0 after a wrap. It is not asserted after `resetCyclic` or reset.
- `periodIn` changes take effect only at the next `resetCyclic`.
- A mid-cycle `resetCyclic` restarts the window sequence from count 0.

## Configuration
- `SYNC_CLK_PHASE_CAPTURE_EN` defined: per-channel `phaseCapture` registers load `syncCounter` on each accepted pulse (UNLOCKED→LOCKED or in-window in LOCKED).
- Undefined: `phaseCapture` is tied to 0, no capture registers are built, and FSM behaviour is unchanged.

## Test plan
All scenarios use P=100, TOLERANCE=2, NUM_CHANNELS=4.
- Release reset, pulse ch0 at count 99 then every 100 clocks for 5 cycles → `channelLocked[0]`=1, `channelError`=0. `phaseCapture` ch0 = 99 (macro on), 0 (macro off).
- Locked ch1, next pulse at count 50 → `channelError[1]`=1 and `errorFlag`=1 one clock later. `clearError` → both 0 and ch1 UNLOCKED next clock.
- Locked ch2, no pulse in the window → `channelError[2]` rises on the clock after count 3. Two pulses at counts 98 and 1 → error after the second pulse.
- `periodIn`=3 with `resetCyclic` → counter wraps at 5 (Peff=6). `cycleTick` every 6 clocks, none right after `resetCyclic`.
- Same cycle: `clearError`, `resetCyclic`, out-of-window pulse on erroring ch3 → ch3 UNLOCKED, no error, counter=0 next clock.
- Assert `reset_n` low mid-cycle at count 57 → all outputs 0 asynchronously. Counter restarts from 0 on release.

Source files
------------

// File: rtl/sync_clk_tracker.sv
// rtl/sync_clk_tracker.sv - multi-channel sync strobe window tracker; optional phase capture under SYNC_CLK_PHASE_CAPTURE_EN
module sync_clk_tracker #(
    parameter int COUNTER_SIZE = 19,
    parameter int NUM_CHANNELS = 4,
    parameter int TOLERANCE    = 2
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 resetCyclic,
    input  logic                                 clearError,
    input  logic [COUNTER_SIZE-1:0]              periodIn,
    input  logic [NUM_CHANNELS-1:0]              syncPulse,
    output logic [COUNTER_SIZE-1:0]              syncCounter,
    output logic                                 cycleTick,
    output logic [NUM_CHANNELS-1:0]              channelLocked,
    output logic [NUM_CHANNELS-1:0]              channelError,
    output logic                                 errorFlag,
    output logic [NUM_CHANNELS*COUNTER_SIZE-1:0] phaseCapture
);

    // Smallest period that still leaves a closed gap between two windows
    localparam logic [COUNTER_SIZE-1:0] MIN_PERIOD = COUNTER_SIZE'(2 * TOLERANCE + 2);
    localparam logic [COUNTER_SIZE-1:0] TOL        = COUNTER_SIZE'(TOLERANCE);
    localparam logic [COUNTER_SIZE-1:0] CLOSE_CNT  = COUNTER_SIZE'(TOLERANCE + 1);
    localparam logic [COUNTER_SIZE-1:0] ONE        = COUNTER_SIZE'(1);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    logic [COUNTER_SIZE-1:0] r_period;
    logic                    r_period_valid;
    logic [COUNTER_SIZE-1:0] r_count;
    logic                    r_tick;
    state_t                  r_state [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] r_seen;
    logic [NUM_CHANNELS-1:0] r_locked;
    logic [NUM_CHANNELS-1:0] r_error;

    logic [COUNTER_SIZE-1:0] w_period;
    logic [COUNTER_SIZE-1:0] w_peff;
    logic [COUNTER_SIZE-1:0] w_last;
    logic [COUNTER_SIZE-1:0] w_win_lo;
    logic                    w_in_window;
    logic                    w_window_close;
    logic [NUM_CHANNELS-1:0] w_accept;

    // Until the first edge after reset release the live periodIn is the period
    assign w_period       = r_period_valid ? r_period : periodIn;
    assign w_peff         = (w_period < MIN_PERIOD) ? MIN_PERIOD : w_period;
    assign w_last         = w_peff - ONE;
    assign w_win_lo       = w_peff - TOL;
    assign w_in_window    = (r_count >= w_win_lo) || (r_count <= TOL);
    assign w_window_close = (r_count == CLOSE_CNT);

    // Latch the period once after reset release and on every resetCyclic
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_period       <= '0;
            r_period_valid <= 1'b0;
        end else if (!r_period_valid || resetCyclic) begin
            r_period       <= periodIn;
            r_period_valid <= 1'b1;
        end
    end

    // Shared cyclic counter; tick marks a natural wrap only, never a restart
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else if (resetCyclic) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else if (r_count >= w_last) begin
            r_count <= '0;
            r_tick  <= 1'b1;
        end else begin
            r_count <= r_count + ONE;
            r_tick  <= 1'b0;
        end
    end

    // A pulse is accepted when it is in the window and is the first one seen there
    always_comb begin
        w_accept = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            w_accept[i] = !clearError && !resetCyclic && syncPulse[i] && w_in_window &&
                          ((r_state[i] == ST_UNLOCKED) ||
                           ((r_state[i] == ST_LOCKED) && !r_seen[i]));
        end
    end

    // Per-channel lock FSM with registered lock/error outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_state[i] <= ST_UNLOCKED;
            end
            r_seen   <= '0;
            r_locked <= '0;
            r_error  <= '0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (clearError) begin
                    r_state[i]  <= ST_UNLOCKED;
                    r_seen[i]   <= 1'b0;
                    r_locked[i] <= 1'b0;
                    r_error[i]  <= 1'b0;
                end else if (resetCyclic) begin
                    // The window sequence restarts from 0, so forget the current window
                    r_seen[i] <= 1'b0;
                    if (r_state[i] == ST_LOCKED) begin
                        r_state[i]  <= ST_UNLOCKED;
                        r_locked[i] <= 1'b0;
                    end
                end else begin
                    if (w_window_close) begin
                        r_seen[i] <= 1'b0;
                    end else if (w_accept[i]) begin
                        r_seen[i] <= 1'b1;
                    end
                    case (r_state[i])
                        ST_UNLOCKED: begin
                            if (w_accept[i]) begin
                                r_state[i]  <= ST_LOCKED;
                                r_locked[i] <= 1'b1;
                            end
                        end
                        ST_LOCKED: begin
                            // Out-of-window pulse, duplicate pulse, or missing pulse at close
                            if ((syncPulse[i] && !w_accept[i]) ||
                                (!syncPulse[i] && w_window_close && !r_seen[i])) begin
                                r_state[i]  <= ST_ERROR;
                                r_locked[i] <= 1'b0;
                                r_error[i]  <= 1'b1;
                            end
                        end
                        ST_ERROR: begin
                            r_state[i] <= ST_ERROR;
                        end
                        default: begin
                            r_state[i]  <= ST_UNLOCKED;
                            r_locked[i] <= 1'b0;
                            r_error[i]  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

`ifdef SYNC_CLK_PHASE_CAPTURE_EN
    logic [COUNTER_SIZE-1:0] r_phase [NUM_CHANNELS];

    // Record the counter value of every accepted pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_phase[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (w_accept[i]) begin
                    r_phase[i] <= r_count;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_phase
        assign phaseCapture[g*COUNTER_SIZE +: COUNTER_SIZE] = r_phase[g];
    end
`else
    assign phaseCapture = '0;
`endif

    assign syncCounter   = r_count;
    assign cycleTick     = r_tick;
    assign channelLocked = r_locked;
    assign channelError  = r_error;
    assign errorFlag     = |r_error;

endmodule
